// File: rtl/frame_channel_arbiter_pkg.sv
// Shared types for the frame channel arbiter: CCI headers, frame requests, grants and TX/RX channels.
// Also holds the request-type encodings and a saturating-increment helper.
package frame_channel_arbiter_pkg;

    localparam int CL_W              = 512;
    localparam int FRAME_ARB_STATS_W = 16;

    localparam logic [3:0] RdLine  = 4'h4;
    localparam logic [3:0] WrLine  = 4'h2;
    localparam logic [3:0] WrFence = 4'h5;

    typedef enum logic {ARB_READER = 1'b0, ARB_WRITER = 1'b1} arb_owner_t;

    typedef struct packed {
        logic [3:0]  req_type;
        logic [31:0] address;
        logic [13:0] mdata;
    } t_cci_hdr;

    typedef struct packed {
        logic afu_en;
    } t_CSR_AFU_STATE;

    typedef struct packed {
        logic            read_request;
        t_cci_hdr        read_header;
        logic            write_request;
        t_cci_hdr        write_header;
        logic [CL_W-1:0] write_data;
    } frame_arb_t;

    typedef struct packed {
        logic reader_grant;
        logic writer_grant;
    } channel_grant_arb_t;

    typedef struct packed {
        t_cci_hdr header;
        logic     rdvalid;
    } tx_c0_t;

    typedef struct packed {
        t_cci_hdr        header;
        logic [CL_W-1:0] data;
        logic            wrvalid;
    } tx_c1_t;

    typedef struct packed {
        logic rdvalid;
    } rx_c0_t;

    function automatic logic is_fence(input t_cci_hdr h);
        return h.req_type == WrFence;
    endfunction

    function automatic logic [FRAME_ARB_STATS_W-1:0] sat_inc(
        input logic [FRAME_ARB_STATS_W-1:0] v, input logic en);
        return (en && v != '1) ? v + FRAME_ARB_STATS_W'(1) : v;
    endfunction

endpackage

// File: rtl/frame_channel_arbiter_if.sv
// Bundle of requester, grant and CCI TX/RX signals around the frame channel arbiter.
// master is the arbiter side; slave is the requesters plus QA shell side.
interface frame_channel_arbiter_if;
    import frame_channel_arbiter_pkg::*;

    frame_arb_t         frame_reader;
    frame_arb_t         frame_writer;
    channel_grant_arb_t read_grant;
    channel_grant_arb_t write_grant;
    rx_c0_t             rx0;
    logic               tx0_almostfull;
    logic               tx1_almostfull;
    tx_c0_t             tx0;
    tx_c1_t             tx1;

    modport master (
        input  frame_reader, frame_writer, rx0, tx0_almostfull, tx1_almostfull,
        output read_grant, write_grant, tx0, tx1
    );

    modport slave (
        output frame_reader, frame_writer, rx0, tx0_almostfull, tx1_almostfull,
        input  read_grant, write_grant, tx0, tx1
    );

endinterface

// File: rtl/frame_channel_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, priority pointer advances only on a grant.
module frame_channel_arbiter_rr_arb2
    import frame_channel_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               resetb,
    input  logic               i_clear,
    input  logic               i_reader_req,
    input  logic               i_writer_req,
    input  logic               i_eligible,
    output channel_grant_arb_t o_grant
);

    arb_owner_t r_prio;
    logic       w_rd;
    logic       w_wr;

    // NOTE: every output of this always_comb is assigned on every path, so no latch is inferred.
    always_comb begin
        w_rd                 = i_eligible && i_reader_req;
        w_wr                 = i_eligible && i_writer_req;
        o_grant.reader_grant = w_rd && (!w_wr || r_prio == ARB_READER);
        o_grant.writer_grant = w_wr && (!w_rd || r_prio == ARB_WRITER);
    end

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!resetb || i_clear)       r_prio <= ARB_READER;
        else if (o_grant.reader_grant) r_prio <= ARB_WRITER;
        else if (o_grant.writer_grant) r_prio <= ARB_READER;
    end

endmodule

// File: rtl/frame_channel_arbiter.sv
// Shares CCI TX0 (RdLine) and TX1 (WrLine/WrFence) between frame_reader and frame_writer.
// Optional grant statistics are built when FRAME_ARB_STATS_EN is defined.
module frame_channel_arbiter
    import frame_channel_arbiter_pkg::*;
#(
    parameter int MAX_RD_OUTSTANDING = 32,
    parameter int LOG_MAX_RD         = 6
) (
    input  logic                       clk,
    input  logic                       resetb,
    input  t_CSR_AFU_STATE             csr,
    frame_channel_arbiter_if.master    bus,
    output logic [63:0]                arb_stats
);

    localparam logic [LOG_MAX_RD-1:0] RD_LIMIT = LOG_MAX_RD'(MAX_RD_OUTSTANDING);

    logic                  w_run;
    logic                  w_tx0_elig;
    logic                  w_tx1_elig;
    logic                  w_rd_inc;
    logic                  w_rd_dec;
    logic                  w_wr_any;
    channel_grant_arb_t    w_rd_gnt;
    channel_grant_arb_t    w_wr_gnt;
    t_cci_hdr              w_rd_hdr;
    t_cci_hdr              w_wr_hdr;
    logic [CL_W-1:0]       w_wr_data;

    logic [LOG_MAX_RD-1:0] r_rd_outstanding;
    logic                  r_fence_hold;
    tx_c0_t                r_tx0;
    tx_c1_t                r_tx1;

    always_comb begin
        w_run      = resetb && csr.afu_en;
        w_tx0_elig = w_run && !bus.tx0_almostfull && (r_rd_outstanding < RD_LIMIT);
        w_tx1_elig = w_run && !bus.tx1_almostfull && !r_fence_hold;
        w_rd_inc   = w_rd_gnt.reader_grant || w_rd_gnt.writer_grant;
        w_rd_dec   = bus.rx0.rdvalid;
        w_wr_any   = w_wr_gnt.reader_grant || w_wr_gnt.writer_grant;
        w_rd_hdr   = w_rd_gnt.writer_grant ? bus.frame_writer.read_header  : bus.frame_reader.read_header;
        w_wr_hdr   = w_wr_gnt.writer_grant ? bus.frame_writer.write_header : bus.frame_reader.write_header;
        w_wr_data  = w_wr_gnt.writer_grant ? bus.frame_writer.write_data   : bus.frame_reader.write_data;
    end

    frame_channel_arbiter_rr_arb2 u_rr_tx0 (
        .clk          (clk),
        .resetb       (resetb),
        .i_clear      (!csr.afu_en),
        .i_reader_req (bus.frame_reader.read_request),
        .i_writer_req (bus.frame_writer.read_request),
        .i_eligible   (w_tx0_elig),
        .o_grant      (w_rd_gnt)
    );

    frame_channel_arbiter_rr_arb2 u_rr_tx1 (
        .clk          (clk),
        .resetb       (resetb),
        .i_clear      (!csr.afu_en),
        .i_reader_req (bus.frame_reader.write_request),
        .i_writer_req (bus.frame_writer.write_request),
        .i_eligible   (w_tx1_elig),
        .o_grant      (w_wr_gnt)
    );

    // Credits are taken at grant time so a grant in flight already counts against the limit.
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_tx0            <= '0;
            r_tx1            <= '0;
            r_fence_hold     <= 1'b0;
            r_rd_outstanding <= '0;
        end else begin
            r_tx0.rdvalid <= w_rd_inc;
            if (w_rd_inc) r_tx0.header <= w_rd_hdr;
            r_tx1.wrvalid <= w_wr_any;
            if (w_wr_any) begin
                r_tx1.header <= w_wr_hdr;
                r_tx1.data   <= w_wr_data;
            end
            r_fence_hold <= w_wr_any && is_fence(w_wr_hdr);
            if (w_rd_inc && !w_rd_dec)
                r_rd_outstanding <= r_rd_outstanding + LOG_MAX_RD'(1);
            else if (!w_rd_inc && w_rd_dec && r_rd_outstanding != '0)
                r_rd_outstanding <= r_rd_outstanding - LOG_MAX_RD'(1);
        end
    end

    // A read response with no read outstanding means the credit accounting is broken.
    always_ff @(posedge clk) begin
        if (w_run && w_rd_dec && !w_rd_inc) assert (r_rd_outstanding != '0);
    end

    assign bus.read_grant  = w_rd_gnt;
    assign bus.write_grant = w_wr_gnt;
    assign bus.tx0         = r_tx0;
    assign bus.tx1         = r_tx1;

`ifdef FRAME_ARB_STATS_EN
    logic [FRAME_ARB_STATS_W-1:0] r_rd_gnt_w;
    logic [FRAME_ARB_STATS_W-1:0] r_rd_gnt_r;
    logic [FRAME_ARB_STATS_W-1:0] r_wr_gnt_w;
    logic [FRAME_ARB_STATS_W-1:0] r_wr_gnt_r;

    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_rd_gnt_w <= '0;
            r_rd_gnt_r <= '0;
            r_wr_gnt_w <= '0;
            r_wr_gnt_r <= '0;
        end else begin
            r_rd_gnt_w <= sat_inc(r_rd_gnt_w, w_rd_gnt.writer_grant);
            r_rd_gnt_r <= sat_inc(r_rd_gnt_r, w_rd_gnt.reader_grant);
            r_wr_gnt_w <= sat_inc(r_wr_gnt_w, w_wr_gnt.writer_grant);
            r_wr_gnt_r <= sat_inc(r_wr_gnt_r, w_wr_gnt.reader_grant);
        end
    end

    assign arb_stats = {r_rd_gnt_w, r_rd_gnt_r, r_wr_gnt_w, r_wr_gnt_r};
`else
    assign arb_stats = '0;
`endif

endmodule

// File: tb/tb_frame_channel_arbiter.sv
// Directed table-driven bench for frame_channel_arbiter with a read-credit limit of 4.
module tb_frame_channel_arbiter;
    import frame_channel_arbiter_pkg::*;

    localparam logic [31:0]     RD_ADDR_R = 32'h0000_0200;
    localparam logic [31:0]     RD_ADDR_W = 32'h0000_0100;
    localparam logic [31:0]     WR_ADDR_R = 32'h0000_0300;
    localparam logic [31:0]     WR_ADDR_W = 32'h0000_0400;
    localparam logic [CL_W-1:0] DATA_R    = {16{32'hAAAA_0001}};
    localparam logic [CL_W-1:0] DATA_W    = {16{32'h5555_0002}};

    logic           clk = 1'b0;
    logic           resetb;
    t_CSR_AFU_STATE csr;
    logic [63:0]    arb_stats;

    always #5 clk = ~clk;

    frame_channel_arbiter_if bus ();

    frame_channel_arbiter #(.MAX_RD_OUTSTANDING(4), .LOG_MAX_RD(3)) dut (
        .clk       (clk),
        .resetb    (resetb),
        .csr       (csr),
        .bus       (bus),
        .arb_stats (arb_stats)
    );

    // Bit 0 of every 2-bit field is the reader, bit 1 the writer.
    typedef struct {
        string      name;
        logic       en;
        logic [1:0] rd_req;
        logic [1:0] wr_req;
        logic [1:0] fence;
        logic       af0;
        logic       af1;
        logic       rx;
        logic [1:0] exp_rd;
        logic [1:0] exp_wr;
        int         exp_cnt;
    } vec_t;

    vec_t vq[$];
    int   checks   = 0;
    int   failures = 0;
    int   st_rd_w  = 0;
    int   st_rd_r  = 0;
    int   st_wr_w  = 0;
    int   st_wr_r  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input string n, input logic en, input logic [1:0] rd, input logic [1:0] wr,
                       input logic [1:0] fence, input logic af0, input logic af1, input logic rx,
                       input logic [1:0] erd, input logic [1:0] ewr, input int cnt);
        vec_t v;
        v = '{n, en, rd, wr, fence, af0, af1, rx, erd, ewr, cnt};
        vq.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        csr.afu_en                             = v.en;
        bus.frame_reader.read_request          = v.rd_req[0];
        bus.frame_writer.read_request          = v.rd_req[1];
        bus.frame_reader.write_request         = v.wr_req[0];
        bus.frame_writer.write_request         = v.wr_req[1];
        bus.frame_reader.write_header.req_type = v.fence[0] ? WrFence : WrLine;
        bus.frame_writer.write_header.req_type = v.fence[1] ? WrFence : WrLine;
        bus.tx0_almostfull                     = v.af0;
        bus.tx1_almostfull                     = v.af1;
        bus.rx0.rdvalid                        = v.rx;
    endtask

    initial begin
        vec_t idle;
        resetb       = 1'b0;
        bus.frame_reader = '0;
        bus.frame_writer = '0;
        bus.frame_reader.read_header  = '{req_type: RdLine, address: RD_ADDR_R, mdata: 14'h11};
        bus.frame_writer.read_header  = '{req_type: RdLine, address: RD_ADDR_W, mdata: 14'h22};
        bus.frame_reader.write_header = '{req_type: WrLine, address: WR_ADDR_R, mdata: 14'h33};
        bus.frame_writer.write_header = '{req_type: WrLine, address: WR_ADDR_W, mdata: 14'h44};
        bus.frame_reader.write_data   = DATA_R;
        bus.frame_writer.write_data   = DATA_W;
        idle = '{"reset", 1'b1, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 0};
        apply(idle);

        repeat (3) @(posedge clk);
        #1;
        check("reset read_grant",  {bus.read_grant.writer_grant, bus.read_grant.reader_grant}, 0);
        check("reset write_grant", {bus.write_grant.writer_grant, bus.write_grant.reader_grant}, 0);
        check("reset tx0.rdvalid", bus.tx0.rdvalid, 0);
        check("reset tx1.wrvalid", bus.tx1.wrvalid, 0);
        check("reset rd_outstanding", dut.r_rd_outstanding, 0);
        check("reset arb_stats", arb_stats, 0);

        // TX1 round robin with both requesters holding.
        add("wr_rr1", 1, 2'b00, 2'b11, 2'b00, 0, 0, 0, 2'b00, 2'b01, 0);
        add("wr_rr2", 1, 2'b00, 2'b11, 2'b00, 0, 0, 0, 2'b00, 2'b10, 0);
        add("wr_rr3", 1, 2'b00, 2'b11, 2'b00, 0, 0, 0, 2'b00, 2'b01, 0);
        add("wr_rr4", 1, 2'b00, 2'b11, 2'b00, 0, 0, 0, 2'b00, 2'b10, 0);
        add("wr_rr5", 1, 2'b00, 2'b11, 2'b00, 0, 0, 0, 2'b00, 2'b01, 0);
        add("wr_rr6", 1, 2'b00, 2'b11, 2'b00, 0, 0, 0, 2'b00, 2'b10, 0);
        add("wr_idle", 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0);
        // Writer RdLine held off by tx0 almost-full.
        add("af0_1", 1, 2'b10, 2'b00, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0);
        add("af0_2", 1, 2'b10, 2'b00, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0);
        add("af0_3", 1, 2'b10, 2'b00, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0);
        add("af0_go", 1, 2'b10, 2'b00, 2'b00, 0, 0, 0, 2'b10, 2'b00, 1);
        add("af0_ret", 1, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b00, 2'b00, 0);
        // Read-credit limit of 4.
        add("cred1", 1, 2'b01, 2'b00, 2'b00, 0, 0, 0, 2'b01, 2'b00, 1);
        add("cred2", 1, 2'b01, 2'b00, 2'b00, 0, 0, 0, 2'b01, 2'b00, 2);
        add("cred3", 1, 2'b01, 2'b00, 2'b00, 0, 0, 0, 2'b01, 2'b00, 3);
        add("cred4", 1, 2'b01, 2'b00, 2'b00, 0, 0, 0, 2'b01, 2'b00, 4);
        add("cred_full", 1, 2'b01, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 4);
        add("cred_rx", 1, 2'b01, 2'b00, 2'b00, 0, 0, 1, 2'b00, 2'b00, 3);
        add("cred_regrant", 1, 2'b01, 2'b00, 2'b00, 0, 0, 0, 2'b01, 2'b00, 4);
        // Simultaneous issue and return at 2.
        add("ret_a", 1, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b00, 2'b00, 3);
        add("ret_b", 1, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b00, 2'b00, 2);
        add("rx_and_tx", 1, 2'b01, 2'b00, 2'b00, 0, 0, 1, 2'b01, 2'b00, 2);
        add("rd_rr_w", 1, 2'b11, 2'b00, 2'b00, 0, 0, 0, 2'b10, 2'b00, 3);
        add("rd_rr_r", 1, 2'b11, 2'b00, 2'b00, 0, 0, 1, 2'b01, 2'b00, 3);
        add("drain1", 1, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b00, 2'b00, 2);
        add("drain2", 1, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b00, 2'b00, 1);
        add("drain3", 1, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b00, 2'b00, 0);
        // Fence ordering, then tx1 almost-full.
        add("fence_pre", 1, 2'b00, 2'b01, 2'b00, 0, 0, 0, 2'b00, 2'b01, 0);
        add("fence_gnt", 1, 2'b00, 2'b11, 2'b10, 0, 0, 0, 2'b00, 2'b10, 0);
        add("fence_hold", 1, 2'b00, 2'b01, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0);
        add("fence_after", 1, 2'b00, 2'b01, 2'b00, 0, 0, 0, 2'b00, 2'b01, 0);
        add("af1_block", 1, 2'b00, 2'b01, 2'b00, 0, 1, 0, 2'b00, 2'b00, 0);
        // afu_en drop mid-burst and re-enable.
        add("burst", 1, 2'b11, 2'b11, 2'b00, 0, 0, 0, 2'b10, 2'b10, 1);
        add("afu_off", 0, 2'b11, 2'b11, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0);
        add("afu_on", 1, 2'b11, 2'b11, 2'b00, 0, 0, 0, 2'b01, 2'b01, 1);
        add("final_ret", 1, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b00, 2'b00, 0);

        @(posedge clk);
        #1;
        resetb = 1'b1;
        for (int i = 0; i < vq.size(); i++) begin
            vec_t v;
            v = vq[i];
            apply(v);
            #3;
            check($sformatf("%s read_grant", v.name),
                  {bus.read_grant.writer_grant, bus.read_grant.reader_grant}, v.exp_rd);
            check($sformatf("%s write_grant", v.name),
                  {bus.write_grant.writer_grant, bus.write_grant.reader_grant}, v.exp_wr);
            @(posedge clk);
            #1;
            check($sformatf("%s tx0.rdvalid", v.name), bus.tx0.rdvalid, |v.exp_rd);
            if (v.exp_rd != 2'b00) begin
                check($sformatf("%s tx0.address", v.name), bus.tx0.header.address,
                      v.exp_rd[1] ? RD_ADDR_W : RD_ADDR_R);
                check($sformatf("%s tx0.req_type", v.name), bus.tx0.header.req_type, RdLine);
            end
            check($sformatf("%s tx1.wrvalid", v.name), bus.tx1.wrvalid, |v.exp_wr);
            if (v.exp_wr != 2'b00) begin
                check($sformatf("%s tx1.address", v.name), bus.tx1.header.address,
                      v.exp_wr[1] ? WR_ADDR_W : WR_ADDR_R);
                check($sformatf("%s tx1.req_type", v.name), bus.tx1.header.req_type,
                      (v.exp_wr[1] ? v.fence[1] : v.fence[0]) ? WrFence : WrLine);
                check($sformatf("%s tx1.data", v.name), bus.tx1.data[63:0],
                      v.exp_wr[1] ? DATA_W[63:0] : DATA_R[63:0]);
            end
            check($sformatf("%s rd_outstanding", v.name), dut.r_rd_outstanding, v.exp_cnt);
            if (!v.en) begin
                st_rd_w = 0; st_rd_r = 0; st_wr_w = 0; st_wr_r = 0;
            end else begin
                st_rd_w += int'(v.exp_rd[1]);
                st_rd_r += int'(v.exp_rd[0]);
                st_wr_w += int'(v.exp_wr[1]);
                st_wr_r += int'(v.exp_wr[0]);
            end
        end

`ifdef FRAME_ARB_STATS_EN
        check("arb_stats", arb_stats,
              {st_rd_w[15:0], st_rd_r[15:0], st_wr_w[15:0], st_wr_r[15:0]});
`else
        check("arb_stats", arb_stats, 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
